// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
package mem_loader_pkg;

  // Loader sequencing: instruction section, data section, then hand-off.
  typedef enum logic [1:0] {
    LOAD_INST = 2'd0,
    LOAD_DATA = 2'd1,
    RUN       = 2'd2,
    ERROR     = 2'd3
  } ld_state_e;

  localparam int INST_BYTES = 4;
  localparam int DATA_BYTES = 8;

  // Byte counter wide enough to hold DATA_BYTES itself.
  localparam int CNT_W = $clog2(DATA_BYTES) + 1;

endpackage

// File: rtl/mem_loader_packer.sv
// Byte-to-word assembler shared by both sections; word size chosen per byte.
module byte_packer #(
  parameter int MAX_BYTES = 8,
  parameter int CW        = $clog2(MAX_BYTES) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   xfer_i,
  input  logic [7:0]             byte_i,
  input  logic                   last_i,
  input  logic [CW-1:0]          nbytes_i,
  output logic [8*MAX_BYTES-1:0] word_o,
  output logic                   done_o
);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [8*MAX_BYTES-1:0] acc_q, acc_d;
  logic                   done_q, done_d;

  // Place the byte at its little-endian lane; the first byte of a word
  // starts from zero so short (last) words come out zero-filled.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    done_d = 1'b0;
    if (xfer_i) begin
      if (cnt_q == '0) acc_d = '0;
      acc_d[{cnt_q[CW-2:0], 3'b000} +: 8] = byte_i;
      if (last_i || ((cnt_q + CW'(1)) == nbytes_i)) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Word stays stable in the done cycle even if the next word's first
  // byte is accepted in that same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      done_q <= done_d;
    end
  end

  assign word_o = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/mem_loader.sv
// Streams a byte image into instruction then data memory, then enables the core.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 64
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          dmem_we,
  output logic [$clog2(DMEM_WORDS)-1:0] dmem_addr,
  output logic [63:0]                   dmem_wdata,
  output logic                          core_enable,
  output logic                          err
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  ld_state_e      state_q, state_d;
  logic           rdy_q;
  logic [IAW:0]   iaddr_q, iaddr_d;   // one extra bit to detect overflow
  logic [DAW:0]   daddr_q, daddr_d;
  logic           sect_q;             // pending word belongs to data section
  logic           xfer, done;
  logic [CNT_W-1:0] nbytes;
  logic [63:0]    word;

  assign in_ready = rdy_q && (state_q == LOAD_INST || state_q == LOAD_DATA);
  assign xfer     = in_valid && in_ready;
  assign nbytes   = (state_q == LOAD_DATA) ? CNT_W'(DATA_BYTES) : CNT_W'(INST_BYTES);

  byte_packer #(.MAX_BYTES(DATA_BYTES)) u_packer (
    .clk_i    (clk_in),
    .rst_ni   (rst),
    .xfer_i   (xfer),
    .byte_i   (in_data),
    .last_i   (in_last),
    .nbytes_i (nbytes),
    .word_o   (word),
    .done_o   (done)
  );

  // Section transitions happen on the last byte itself, so in_ready drops
  // right after the final data byte; the word it completes is written in
  // the following cycle, tagged by sect_q. Overflow overrides everything.
  always_comb begin
    state_d = state_q;
    iaddr_d = iaddr_q;
    daddr_d = daddr_q;
    imem_we = 1'b0;
    dmem_we = 1'b0;
    case (state_q)
      LOAD_INST: if (xfer && in_last) state_d = LOAD_DATA;
      LOAD_DATA: if (xfer && in_last) state_d = RUN;
      default:   ;
    endcase
    if (done && state_q != ERROR) begin
      if (!sect_q) begin
        if (iaddr_q == (IAW+1)'(IMEM_WORDS)) state_d = ERROR;
        else begin
          imem_we = 1'b1;
          iaddr_d = iaddr_q + (IAW+1)'(1);
        end
      end else begin
        if (daddr_q == (DAW+1)'(DMEM_WORDS)) state_d = ERROR;
        else begin
          dmem_we = 1'b1;
          daddr_d = daddr_q + (DAW+1)'(1);
        end
      end
    end
  end

  // State, address counters and section tag; in_ready held off until the
  // first edge after reset release.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD_INST;
      rdy_q   <= 1'b0;
      iaddr_q <= '0;
      daddr_q <= '0;
      sect_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      iaddr_q <= iaddr_d;
      daddr_q <= daddr_d;
      if (xfer) sect_q <= (state_q == LOAD_DATA);
    end
  end

  assign imem_addr   = iaddr_q[IAW-1:0];
  assign dmem_addr   = daddr_q[DAW-1:0];
  assign imem_wdata  = word[31:0];
  assign dmem_wdata  = word;
  // Held low during the final data write so the core starts one cycle later.
  assign core_enable = (state_q == RUN) && !done;
  assign err         = (state_q == ERROR);

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter DMEM_WORDS, default 64, meaning data memory depth in 64-bit words.
REQ-003 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 SHALL have port in_data  input  8  stream byte, little-endian within each word.
REQ-007 SHALL have port in_last  input  1  marks the final byte of the current section.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port imem_addr  output  $clog2(IMEM_WORDS)  instruction word index.
REQ-011 SHALL have port imem_wdata  output  32  instruction word.
REQ-012 SHALL have port dmem_we  output  1  data-memory write strobe.
REQ-013 SHALL have port dmem_addr  output  $clog2(DMEM_WORDS)  data word index; byte address = index*8.
REQ-014 SHALL have port dmem_wdata  output  64  data word.
REQ-015 SHALL have port core_enable  output  1  drives the pipeline enable input.
REQ-016 SHALL have port err  output  1  sticky overflow flag.

Function
REQ-017 SHALL implement states LOAD_INST, LOAD_DATA, RUN, ERROR; reset state LOAD_INST.
REQ-018 SHALL accept a byte only when in_valid && in_ready (a transfer).
REQ-019 SHALL drive in_ready=1 in LOAD_INST and LOAD_DATA, and 0 in RUN and ERROR.
REQ-020 SHALL pack bytes LSB-first: byte k of a word lands in bits [8k+7:8k].
REQ-021 LOAD_INST: after the 4th byte of a word, or on a transfer with in_last, SHALL pulse imem_we for exactly one cycle, in the cycle following that transfer.
REQ-022 Partial words (in_last before 4 bytes) SHALL be written with unfilled upper bytes zero.
REQ-023 imem_addr SHALL start at 0 and increment by 1 after each imem_we pulse.
REQ-024 A transfer with in_last in LOAD_INST SHALL move to LOAD_DATA, with the byte counter cleared; in_ready stays 1.
REQ-025 LOAD_DATA SHALL behave as REQ-021..REQ-023 with 8-byte words on dmem_we/dmem_addr/dmem_wdata.
REQ-026 A transfer with in_last in LOAD_DATA SHALL move to RUN after the final dmem_we pulse.
REQ-027 core_enable SHALL assert the cycle after the final dmem_we pulse (2 cycles after the last byte) and hold until reset.
REQ-028 A word write whose index would equal IMEM_WORDS (DMEM_WORDS) SHALL be suppressed; instead the block enters ERROR.
REQ-029 In ERROR: err=1, no writes, core_enable=0; leave only by reset.
REQ-030 Transfers SHALL be accepted back-to-back with no bubbles, including the cycle of a write pulse.
REQ-031 imem_we and dmem_we SHALL never assert in the same cycle.

Reset
REQ-032 On rst low, all outputs SHALL be 0 except in_ready, which is 0 while rst is low and 1 from the first clock edge after release.
REQ-033 Reset mid-load SHALL discard the partial word and restart at LOAD_INST, index 0; memory contents are left untouched.

Structure
REQ-034 The state enum and the constants INST_BYTES=4 and DATA_BYTES=8 SHALL live in the shared pipeline package.
REQ-035 A single sub-module, byte_packer (byte counter plus shift assembly, width parameter), SHALL be instantiated once, for both sections.

Verification
REQ-036 Stream 8 bytes 13,00,00,93 / 00,10,01,13, last on byte 8, then 8 data bytes 01..08, last on byte 8 -> imem[0]=93000013, imem[1]=13011000, dmem[0]=0807060504030201, core_enable high 2 cycles after byte 16.
REQ-037 Instruction section of 6 bytes AA,BB,CC,DD,EE,FF with last on FF -> imem[1]=0000FFEE, then transition to LOAD_DATA.
REQ-038 Random in_valid gaps, 50% duty -> written contents identical to the gapless run of REQ-036.
REQ-039 IMEM_WORDS=2, 12 instruction bytes -> exactly two imem_we pulses, err=1, in_ready=0, core_enable stays 0.
REQ-040 rst low after 3 bytes, then replay REQ-036 -> identical result, no write from the discarded partial word.
REQ-041 Assertions: imem_we/dmem_we mutually exclusive; core_enable never falls without reset.
